card_slot_allocator: RTL and testbench

- Free-list allocator for the shared 1024x32 card RAM.
- Sits directly upstream of the card-store stage. It hands out an unused card address when a new list node is needed, and it takes back addresses released by card removal.
- Address 0 is permanently reserved as the null "end of list" link and is never handed out.
- Scans a one-bit-per-slot occupancy map with a rotating pointer and reports the result with a one-cycle done/fail pulse.

---
 rtl/card_slot_allocator.sv | 130 +++++++++++++
 tb/tb_card_slot_allocator.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/card_slot_allocator.sv
// Free-list allocator for the 1024x32 card RAM.
// Rotating-pointer scan over an occupancy map; slot 0 is the null link.
module card_slot_allocator #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1 << ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              alloc_req,
    output logic              alloc_done,
    output logic [ADDR_W-1:0] alloc_addr,
    output logic              alloc_fail,
    input  logic              free_req,
    input  logic [ADDR_W-1:0] free_addr,
    output logic              free_err,
    output logic [ADDR_W:0]   free_count,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DONE
    } state_t;

    localparam logic [ADDR_W:0]   CNT_MAX = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] PTR_MAX = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] PTR_MIN = ADDR_W'(1);

    state_t            state_q;
    logic [DEPTH-1:0]  map_q;
    logic [DEPTH-1:0]  map_d;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] ptr_d;
    logic [ADDR_W:0]   cnt_q;
    logic [ADDR_W:0]   cnt_d;
    logic [ADDR_W-1:0] addr_q;
    logic              done_q;
    logic              fail_q;
    logic              err_q;
    logic              busy_q;

    logic scan_hit;
    logic free_ok;
    logic free_bad;

    always_comb begin
        scan_hit = (state_q == S_SCAN) && !map_q[ptr_q];
        free_ok  = free_req && (free_addr != '0) && map_q[free_addr];
        free_bad = free_req && !free_ok;
        ptr_d    = (ptr_q == PTR_MAX) ? PTR_MIN : ptr_q + 1'b1;
    end

    // The scan reads the pre-free map; a slot freed this cycle shows up next cycle.
    always_comb begin
        map_d = map_q;
        if (scan_hit) begin
            map_d[ptr_q] = 1'b1;
        end
        if (free_ok) begin
            map_d[free_addr] = 1'b0;
        end
        map_d[0] = 1'b1;
    end

    always_comb begin
        cnt_d = cnt_q;
        unique case ({scan_hit, free_ok})
            2'b10:   cnt_d = cnt_q - 1'b1;
            2'b01:   cnt_d = cnt_q + 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            map_q   <= {{(DEPTH-1){1'b0}}, 1'b1};
            ptr_q   <= PTR_MIN;
            cnt_q   <= CNT_MAX;
            addr_q  <= '0;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            map_q  <= map_d;
            cnt_q  <= cnt_d;
            err_q  <= free_bad;
            done_q <= 1'b0;
            fail_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (alloc_req) begin
                        if (cnt_q == '0) begin
                            fail_q <= 1'b1;
                        end else begin
                            state_q <= S_SCAN;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                S_SCAN: begin
                    ptr_q <= ptr_d;
                    if (scan_hit) begin
                        addr_q  <= ptr_q;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign alloc_done = done_q;
    assign alloc_addr = addr_q;
    assign alloc_fail = fail_q;
    assign free_err   = err_q;
    assign free_count = cnt_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_card_slot_allocator.sv
// Directed bench for card_slot_allocator.
// Hand-computed addresses, latencies and counts checked with immediate assertions.
module tb_card_slot_allocator;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1024;

    logic              clock;
    logic              reset;
    logic              alloc_req;
    logic              alloc_done;
    logic [ADDR_W-1:0] alloc_addr;
    logic              alloc_fail;
    logic              free_req;
    logic [ADDR_W-1:0] free_addr;
    logic              free_err;
    logic [ADDR_W:0]   free_count;
    logic              busy;

    int n_cmp = 0;
    int n_err = 0;

    card_slot_allocator #(
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .alloc_req (alloc_req),
        .alloc_done(alloc_done),
        .alloc_addr(alloc_addr),
        .alloc_fail(alloc_fail),
        .free_req  (free_req),
        .free_addr (free_addr),
        .free_err  (free_err),
        .free_count(free_count),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_alloc(output int lat, output logic got_done, output logic got_fail);
        lat       = 0;
        got_done  = 1'b0;
        got_fail  = 1'b0;
        alloc_req = 1'b1;
        for (int i = 0; i < 1100; i++) begin
            tick();
            lat++;
            alloc_req = 1'b0;
            if (alloc_done) begin
                got_done = 1'b1;
                break;
            end
            if (alloc_fail) begin
                got_fail = 1'b1;
                break;
            end
        end
        if (!got_done && !got_fail) chk("alloc_timeout", 0, 1);
        tick();
    endtask

    task automatic do_free(input int a);
        free_req  = 1'b1;
        free_addr = ADDR_W'(a);
        tick();
        free_req  = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_done"}, int'(alloc_done), 0);
        chk({tag, "_fail"}, int'(alloc_fail), 0);
        chk({tag, "_err"}, int'(free_err), 0);
        chk({tag, "_addr"}, int'(alloc_addr), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_count"}, int'(free_count), 1023);
    endtask

    initial begin
        int   lat;
        logic gd;
        logic gf;
        int   bad;
        int   last;

        reset     = 1'b1;
        alloc_req = 1'b0;
        free_req  = 1'b0;
        free_addr = '0;
        tick();
        tick();
        check_reset_outputs("rst");
        reset = 1'b0;
        tick();

        // three single allocations from a fresh map
        for (int k = 1; k <= 3; k++) begin
            alloc_req = 1'b1;
            tick();
            chk("busy_scan", int'(busy), 1);
            alloc_req = 1'b0;
            tick();
            chk("first_done", int'(alloc_done), 1);
            chk("first_addr", int'(alloc_addr), k);
            tick();
            chk("done_pulse", int'(alloc_done), 0);
        end
        chk("count_1020", int'(free_count), 1020);

        // rotating pointer does not return to freed slot 2
        do_free(2);
        chk("free2_err", int'(free_err), 0);
        chk("free2_count", int'(free_count), 1021);
        do_alloc(lat, gd, gf);
        chk("rot_done", int'(gd), 1);
        chk("rot_addr", int'(alloc_addr), 4);
        chk("rot_lat", lat, 2);
        chk("rot_count", int'(free_count), 1020);

        // exhaust the map: 5..1023 then wrap to 2
        bad  = 0;
        last = 0;
        for (int k = 0; k < 1020; k++) begin
            do_alloc(lat, gd, gf);
            if (!gd) bad++;
            last = int'(alloc_addr);
        end
        chk("fill_all_done", bad, 0);
        chk("fill_last_addr", last, 2);
        chk("fill_count", int'(free_count), 0);

        alloc_req = 1'b1;
        tick();
        alloc_req = 1'b0;
        chk("full_fail", int'(alloc_fail), 1);
        chk("full_nodone", int'(alloc_done), 0);
        chk("full_busy", int'(busy), 0);
        tick();
        chk("full_fail_pulse", int'(alloc_fail), 0);
        chk("full_nodone2", int'(alloc_done), 0);

        do_free(500);
        chk("free500_count", int'(free_count), 1);
        do_alloc(lat, gd, gf);
        chk("wrap_done", int'(gd), 1);
        chk("wrap_addr", int'(alloc_addr), 500);
        chk("wrap_lat", lat, 499);
        chk("wrap_count", int'(free_count), 0);

        // null link and double free
        do_free(0);
        chk("free0_err", int'(free_err), 1);
        chk("free0_count", int'(free_count), 0);
        tick();
        chk("free0_err_pulse", int'(free_err), 0);
        do_free(7);
        chk("free7_err", int'(free_err), 0);
        chk("free7_count", int'(free_count), 1);
        do_free(7);
        chk("dbl7_err", int'(free_err), 1);
        chk("dbl7_count", int'(free_count), 1);
        tick();

        // reset in the middle of a scan
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 5; k++) do_alloc(lat, gd, gf);
        chk("pre_mid_count", int'(free_count), 1018);
        alloc_req = 1'b1;
        tick();
        alloc_req = 1'b0;
        chk("mid_busy", int'(busy), 1);
        reset = 1'b1;
        tick();
        check_reset_outputs("midrst");
        reset = 1'b0;
        tick();
        chk("midrst_nodone", int'(alloc_done), 0);
        do_alloc(lat, gd, gf);
        chk("post_rst_addr", int'(alloc_addr), 1);
        chk("post_rst_count", int'(free_count), 1022);

        // free slot 3 on the same edge the scan takes slot 6
        for (int k = 0; k < 4; k++) do_alloc(lat, gd, gf);
        chk("pre_same_count", int'(free_count), 1018);
        alloc_req = 1'b1;
        tick();
        alloc_req = 1'b0;
        free_req  = 1'b1;
        free_addr = ADDR_W'(3);
        tick();
        free_req  = 1'b0;
        chk("same_done", int'(alloc_done), 1);
        chk("same_addr", int'(alloc_addr), 6);
        chk("same_count", int'(free_count), 1018);
        chk("same_err", int'(free_err), 0);
        tick();
        do_free(3);
        chk("bit3_clear_err", int'(free_err), 1);
        chk("bit3_count", int'(free_count), 1018);
        do_free(6);
        chk("bit6_set_err", int'(free_err), 0);
        chk("bit6_count", int'(free_count), 1019);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
